// File: rtl/aes_256_round_sched.sv
// aes_256_round_sched: iterative AES-256 round sequencer (initial ARK, rounds 1-13 on the full-round unit, round 14 on the final-round unit)
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready input block handshake; in_text block, in_decrypt mode (sampled on accept)
//   key_idx, key_i    round-key store index and same-cycle key return
//   dp_text_o, dp_key_o, dp_inv_o  state, key and inverse enable to the round units
//   dp_round_i, dp_final_i         combinational full-round and final-round results
//   out_valid/out_ready, out_text  result handshake and value
//   busy              high while a block is in flight or waiting to be taken
// Optional: define AES_SCHED_ABORT_EN to add the abort input.
module aes_256_round_sched (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_text,
  input  logic         in_decrypt,
  output logic [3:0]   key_idx,
  input  logic [127:0] key_i,
  output logic [127:0] dp_text_o,
  output logic [127:0] dp_key_o,
  output logic         dp_inv_o,
  input  logic [127:0] dp_round_i,
  input  logic [127:0] dp_final_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_text,
  output logic         busy
`ifdef AES_SCHED_ABORT_EN
  ,
  input  logic         abort
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         mode_q, mode_d;
  logic [127:0] text_q, text_d;
  logic         abort_w;
`ifdef AES_SCHED_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif
  assign in_ready  = (state_q == IDLE) && !abort_w;
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign out_valid = (state_q == DONE);
  assign dp_inv_o  = (state_q == RUN) && mode_q;
  assign dp_text_o = text_q;
  assign out_text  = text_q;
  assign dp_key_o  = key_i;
  // Decrypt walks the key store backwards; in IDLE the index follows the port so the initial ARK key is ready at acceptance.
  assign key_idx = (state_q == RUN) ? (mode_q ? 4'd14 - rnd_q : rnd_q)
                 : (state_q == IDLE) ? (in_decrypt ? 4'd14 : 4'd0) : 4'd0;
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    mode_d  = mode_q;
    text_d  = text_q;
    case (state_q)
      IDLE: if (in_valid && in_ready) begin
        text_d  = in_text ^ key_i;
        mode_d  = in_decrypt;
        rnd_d   = 4'd1;
        state_d = RUN;
      end
      RUN: if (rnd_q > 4'd14) state_d = IDLE;
        else if (rnd_q == 4'd14) begin
          text_d  = dp_final_i;
          state_d = DONE;
        end else begin
          text_d = dp_round_i;
          rnd_d  = rnd_q + 4'd1;
        end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_w && state_q != IDLE) state_d = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rnd_q   <= 4'd0;
      mode_q  <= 1'b0;
      text_q  <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      mode_q  <= mode_d;
      text_q  <= text_d;
    end
  end
endmodule
